// File: rtl/usb_fx2_fifo_bridge.sv
// FX2 slave-FIFO bridge: OUT endpoint bursts to an RX stream, TX cache packets to the IN endpoint.
// The shared FD bus is arbitrated by one FSM, and every bus direction change passes through TURN.
module usb_fx2_fifo_bridge #(
  parameter int                   DATA_W     = 16,
  parameter int                   ADDR_W     = 9,
  parameter int                   FIFOADR_W  = 2,
  parameter logic [FIFOADR_W-1:0] RD_FIFOADR = 2'b00,
  parameter logic [FIFOADR_W-1:0] WR_FIFOADR = 2'b10,
  parameter int                   PKT_WORDS  = 256,
  parameter int                   TURN_CYC   = 2
) (
  input  logic                 i_ifclk,
  input  logic                 i_rst,
  input  logic                 i_f_empty,
  input  logic                 i_f_full,
  input  logic [DATA_W-1:0]    i_rdata,
  output logic                 o_sloe,
  output logic                 o_slrd,
  output logic                 o_slwr,
  output logic                 o_wen,
  output logic [DATA_W-1:0]    o_wdata,
  output logic                 o_pkend,
  output logic [FIFOADR_W-1:0] o_fifoaddr,
  output logic                 o_rx_vd,
  output logic [DATA_W-1:0]    o_rx_data,
  output logic                 o_rx_sop,
  output logic                 o_rx_eop,
  input  logic                 i_rx_ready,
  input  logic                 i_tx_req,
  input  logic [ADDR_W:0]      i_tx_len,
  output logic                 o_tx_busy,
  output logic                 o_tx_done,
  output logic [ADDR_W-1:0]    o_tx_addr,
  input  logic [DATA_W-1:0]    i_tx_data
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int RXC_W = $clog2(PKT_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_OE, S_RX_RD, S_TURN, S_TX_PRE, S_TX_WR, S_TX_END
  } state_t;

  state_t              r_state, w_next;
  logic                r_tx_busy, r_tx_done;
  logic [CNT_W-1:0]    r_tx_len, r_issued, r_sent;
  logic [RXC_W-1:0]    r_rx_cnt;
  logic [2:0]          r_turn_cnt;
  logic [ADDR_W-1:0]   r_tx_addr;
  logic                r_pend, r_wptr, r_rptr;
  logic [1:0]          r_buf_cnt;
  logic [DATA_W-1:0]   r_buf [2];

  logic                w_tx_pend, w_rx_end, w_need_pkend, w_tx_act;
  logic                w_slrd, w_slwr, w_issue;
  logic [1:0]          w_occ;

  assign w_tx_pend    = r_tx_busy | i_tx_req;
  assign w_rx_end     = i_f_empty | (r_rx_cnt == RXC_W'(PKT_WORDS)) | r_tx_busy;
  assign w_need_pkend = (r_tx_len == '0) | ((r_tx_len % CNT_W'(PKT_WORDS)) != '0);
  assign w_tx_act     = (r_state == S_TX_PRE) | (r_state == S_TX_WR) | (r_state == S_TX_END);
  // Words held or in flight from the cache; a new read is issued only if it will have a slot.
  assign w_occ        = r_buf_cnt + {1'b0, r_pend};

  always_comb begin
    w_next     = r_state;
    o_sloe     = 1'b0;
    o_wen      = 1'b0;
    w_slrd     = 1'b0;
    w_slwr     = 1'b0;
    w_issue    = 1'b0;
    o_pkend    = 1'b0;
    o_rx_eop   = 1'b0;
    o_fifoaddr = RD_FIFOADR;
    case (r_state)
      S_IDLE: begin
        if (w_tx_pend)       w_next = S_TURN;
        else if (!i_f_empty) w_next = S_RX_OE;
      end
      S_RX_OE: begin
        o_sloe = 1'b1;
        w_next = S_RX_RD;
      end
      S_RX_RD: begin
        o_sloe = 1'b1;
        if (w_rx_end) begin
          o_rx_eop = 1'b1;
          w_next   = r_tx_busy ? S_TURN : S_IDLE;
        end else begin
          w_slrd = i_rx_ready;
        end
      end
      S_TURN: begin
        if (r_turn_cnt == 3'(TURN_CYC - 1)) w_next = r_tx_busy ? S_TX_PRE : S_IDLE;
      end
      S_TX_PRE: begin
        o_wen      = 1'b1;
        o_fifoaddr = WR_FIFOADR;
        w_issue    = (r_tx_len != '0);
        w_next     = S_TX_WR;
      end
      S_TX_WR: begin
        o_wen      = 1'b1;
        o_fifoaddr = WR_FIFOADR;
        w_slwr     = !i_f_full && (r_buf_cnt != 2'd0);
        w_issue    = (r_issued != r_tx_len) && (w_occ <= 2'd1 + {1'b0, w_slwr});
        if ((r_sent == r_tx_len) || (w_slwr && (r_sent + CNT_W'(1) == r_tx_len)))
          w_next = S_TX_END;
      end
      S_TX_END: begin
        o_wen      = 1'b1;
        o_fifoaddr = WR_FIFOADR;
        if (!w_need_pkend || !i_f_full) begin
          o_pkend = w_need_pkend;
          w_next  = S_TURN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_ifclk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_len   <= '0;
      r_rx_cnt   <= '0;
      r_turn_cnt <= '0;
      r_tx_addr  <= '0;
      r_issued   <= '0;
      r_sent     <= '0;
      r_pend     <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_buf_cnt  <= 2'd0;
    end else begin
      r_state   <= w_next;
      r_tx_done <= 1'b0;
      if (r_state == S_TX_END && w_next == S_TURN) begin
        r_tx_done <= 1'b1;
        r_tx_busy <= 1'b0;
      end else if (i_tx_req && !r_tx_busy) begin
        r_tx_busy <= 1'b1;
        r_tx_len  <= i_tx_len;
      end

      if (r_state == S_RX_OE)  r_rx_cnt <= '0;
      else if (w_slrd)         r_rx_cnt <= r_rx_cnt + RXC_W'(1);

      r_turn_cnt <= (r_state == S_TURN) ? r_turn_cnt + 3'd1 : 3'd0;

      if (w_tx_act) begin
        r_pend    <= w_issue;
        r_buf_cnt <= r_buf_cnt + {1'b0, r_pend} - {1'b0, w_slwr};
        if (r_pend) r_wptr <= ~r_wptr;
        if (w_slwr) begin
          r_rptr <= ~r_rptr;
          r_sent <= r_sent + CNT_W'(1);
        end
        if (w_issue) begin
          r_tx_addr <= r_tx_addr + ADDR_W'(1);
          r_issued  <= r_issued + CNT_W'(1);
        end
      end else begin
        r_pend    <= 1'b0;
        r_buf_cnt <= 2'd0;
        r_wptr    <= 1'b0;
        r_rptr    <= 1'b0;
        r_sent    <= '0;
        r_issued  <= '0;
        r_tx_addr <= '0;
      end
    end
  end

  // Cache read data lands one cycle after its address was presented.
  always_ff @(posedge i_ifclk) begin
    if (r_pend) r_buf[r_wptr] <= i_tx_data;
  end

  assign o_slrd    = w_slrd;
  assign o_slwr    = w_slwr;
  assign o_wdata   = r_buf[r_rptr];
  assign o_rx_vd   = w_slrd;
  assign o_rx_data = i_rdata;
  assign o_rx_sop  = w_slrd & (r_rx_cnt == '0);
  assign o_tx_busy = r_tx_busy;
  assign o_tx_done = r_tx_done;
  assign o_tx_addr = r_tx_addr;

endmodule

// File: tb/tb_usb_fx2_fifo_bridge.sv
// Bench for usb_fx2_fifo_bridge: FX2 FIFO and TX cache models, queue-based reference for RX/TX streams.
module tb_usb_fx2_fifo_bridge;
  localparam int TURN_CYC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_empty = 1'b1;
  logic        f_full = 1'b0;
  logic        rx_ready = 1'b1;
  logic [15:0] rdata = 16'h0;
  logic        tx_req = 1'b0;
  logic [9:0]  tx_len = 10'd0;
  logic [15:0] tx_data = 16'h0;
  logic        o_sloe, o_slrd, o_slwr, o_wen, o_pkend, o_rx_vd, o_rx_sop, o_rx_eop, o_tx_busy, o_tx_done;
  logic [15:0] o_wdata, o_rx_data;
  logic [1:0]  o_fifoaddr;
  logic [8:0]  o_tx_addr;

  usb_fx2_fifo_bridge #(.DATA_W(16), .ADDR_W(9), .FIFOADR_W(2), .RD_FIFOADR(2'b00),
                        .WR_FIFOADR(2'b10), .PKT_WORDS(256), .TURN_CYC(TURN_CYC)) dut (
    .i_ifclk(clk), .i_rst(rst), .i_f_empty(f_empty), .i_f_full(f_full), .i_rdata(rdata),
    .o_sloe(o_sloe), .o_slrd(o_slrd), .o_slwr(o_slwr), .o_wen(o_wen), .o_wdata(o_wdata),
    .o_pkend(o_pkend), .o_fifoaddr(o_fifoaddr), .o_rx_vd(o_rx_vd), .o_rx_data(o_rx_data),
    .o_rx_sop(o_rx_sop), .o_rx_eop(o_rx_eop), .i_rx_ready(rx_ready), .i_tx_req(tx_req),
    .i_tx_len(tx_len), .o_tx_busy(o_tx_busy), .o_tx_done(o_tx_done), .o_tx_addr(o_tx_addr),
    .i_tx_data(tx_data));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [15:0] mem [0:511];
  logic [15:0] out_q[$], rx_exp[$], rx_got[$], tx_got[$];
  int burst_lens[$], eop_gaps[$];
  int push_total = 0, pushed = 0, full_mode = 0, rdy_mode = 0, full_tick = 0;
  int cyc = 0, cur_burst = 0, last_vd_cyc = 0, last_slwr_cyc = 0, last_pkend_cyc = 0;
  int sop_cnt = 0, eop_cnt = 0, pkend_cnt = 0, done_cnt = 0, stall_cnt = 0;
  int last_dir = 0, last_rd_cyc = 0, last_wr_cyc = 0, last_gap = 0;
  logic mon_slrd = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FX2 side: OUT FIFO fed by the host, IN FIFO full flag patterns, sink readiness, cache RAM.
  always @(posedge clk) begin
    logic [15:0] w;
    if (mon_slrd && out_q.size() > 0) void'(out_q.pop_front());
    while (pushed < push_total) begin
      w = 16'($urandom);
      out_q.push_back(w);
      rx_exp.push_back(w);
      pushed++;
    end
    f_empty <= (out_q.size() == 0);
    rdata   <= (out_q.size() > 0) ? out_q[0] : 16'($urandom);
    full_tick++;
    case (full_mode)
      1:       if (full_tick % 7 == 0) f_full <= ~f_full;
      2:       f_full <= ($urandom_range(0, 2) == 0);
      default: f_full <= 1'b0;
    endcase
    case (rdy_mode)
      0:       rx_ready <= 1'b1;
      1:       rx_ready <= ($urandom_range(0, 3) != 0);
      default: rx_ready <= 1'b0;
    endcase
    tx_data <= mem[o_tx_addr];
  end

  always @(negedge clk) begin
    cyc++;
    mon_slrd = o_slrd;
    if (o_rx_vd || o_slrd) check("rx_vd_is_slrd", {o_rx_vd, o_rx_data}, {o_slrd, rdata});
    if (o_slrd) check("slrd_legal", {f_empty, rx_ready, o_sloe, o_wen, o_fifoaddr}, {4'b0110, 2'b00});
    if (o_rx_vd) begin
      rx_got.push_back(o_rx_data);
      cur_burst++;
      last_vd_cyc = cyc;
      if (o_rx_sop) begin sop_cnt++; check("sop_first", cur_burst, 1); end
    end
    if (o_rx_eop) begin
      eop_cnt++;
      check("eop_no_vd", o_rx_vd, 0);
      burst_lens.push_back(cur_burst);
      eop_gaps.push_back(cyc - last_vd_cyc);
      cur_burst = 0;
    end
    if (o_slwr) begin
      tx_got.push_back(o_wdata);
      last_slwr_cyc = cyc;
      check("slwr_legal", {f_full, o_wen, o_sloe, o_fifoaddr}, {3'b010, 2'b10});
    end
    if (o_pkend) begin
      pkend_cnt++;
      last_pkend_cyc = cyc;
      check("pkend_legal", {f_full, o_slwr, o_fifoaddr}, {2'b00, 2'b10});
    end
    if (o_tx_done) done_cnt++;
    if (o_sloe && !rx_ready && !f_empty) stall_cnt++;
    if (o_sloe || o_wen) check("bus_contention", o_sloe & o_wen, 0);
    if (o_sloe) begin
      if (last_dir == 2) begin
        last_gap = cyc - last_wr_cyc - 1;
        check("turn_wr2rd", last_gap >= TURN_CYC, 1);
      end
      last_dir = 1; last_rd_cyc = cyc;
    end
    if (o_wen) begin
      if (last_dir == 1) begin
        last_gap = cyc - last_rd_cyc - 1;
        check("turn_rd2wr", last_gap >= TURN_CYC, 1);
      end
      last_dir = 2; last_wr_cyc = cyc;
    end
  end

  task automatic send_tx(input int len);
    @(posedge clk); #1;
    tx_req = 1'b1; tx_len = 10'(len);
    @(posedge clk); #1;
    tx_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin @(negedge clk); n++; end
    check({tag, "_done_seen"}, done_cnt >= target, 1);
  endtask

  task automatic wait_eop(input int target, input int budget, input string tag);
    int n = 0;
    while (eop_cnt < target && n < budget) begin @(negedge clk); n++; end
    check({tag, "_eop_seen"}, eop_cnt >= target, 1);
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_rx_count"}, rx_got.size(), rx_exp.size());
    for (int i = 0; i < rx_got.size() && i < rx_exp.size(); i++)
      check({tag, "_rx_word"}, rx_got[i], rx_exp[i]);
  endtask

  task automatic clear_rx();
    rx_got.delete(); rx_exp.delete(); burst_lens.delete(); eop_gaps.delete();
  endtask

  task automatic run_tx(input string tag, input int len, input int fmode);
    int d0, p0, need;
    full_mode = fmode; tx_got.delete();
    d0 = done_cnt; p0 = pkend_cnt;
    send_tx(len);
    @(negedge clk);
    check({tag, "_busy"}, o_tx_busy, 1);
    wait_done(d0 + 1, len * 6 + 200, tag);
    repeat (3) @(negedge clk);
    need = (len == 0 || len % 256 != 0) ? 1 : 0;
    check({tag, "_tx_count"}, tx_got.size(), len);
    for (int i = 0; i < tx_got.size() && i < len; i++)
      check({tag, "_tx_word"}, tx_got[i], mem[i]);
    check({tag, "_pkend"}, pkend_cnt - p0, need);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_idle"}, o_tx_busy, 0);
    if (need == 1 && len > 0) check({tag, "_pkend_last"}, last_pkend_cyc > last_slwr_cyc, 1);
    full_mode = 0;
  endtask

  initial begin
    int e0, d0, p0, n;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_strobes", {o_sloe, o_slrd, o_slwr, o_wen, o_pkend}, 0);
    check("rst_rx", {o_rx_vd, o_rx_sop, o_rx_eop}, 0);
    check("rst_tx", {o_tx_busy, o_tx_done}, 0);
    check("rst_fifoaddr", o_fifoaddr, 2'b00);
    check("rst_tx_addr", o_tx_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_bus", {o_sloe, o_wen, o_fifoaddr}, 0);

    // Five-word burst
    clear_rx(); e0 = eop_cnt; n = sop_cnt;
    push_total += 5;
    wait_eop(e0 + 1, 100, "t1");
    repeat (3) @(negedge clk);
    check_rx("t1");
    check("t1_sop", sop_cnt - n, 1);
    check("t1_eop", eop_cnt - e0, 1);
    check("t1_eop_gap", (eop_gaps.size() > 0) ? eop_gaps[0] : -1, 1);

    // Eight-word burst with a three-cycle sink stall
    clear_rx(); e0 = eop_cnt; n = sop_cnt; stall_cnt = 0;
    push_total += 8;
    d0 = 0;
    while (rx_got.size() < 3 && d0 < 100) begin @(negedge clk); d0++; end
    rdy_mode = 2;
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    wait_eop(e0 + 1, 100, "t2");
    repeat (3) @(negedge clk);
    check_rx("t2");
    check("t2_stall", stall_cnt, 3);
    check("t2_sop", sop_cnt - n, 1);
    check("t2_eop", eop_cnt - e0, 1);

    // TX: full packet, short packet, ZLP, random lengths, max length
    run_tx("t3_len256", 256, 1);
    run_tx("t4_len10", 10, 2);
    run_tx("t4_zlp", 0, 1);
    for (int k = 0; k < 3; k++) run_tx("rnd_tx", $urandom_range(1, 511), 2);
    run_tx("len512", 512, 2);

    // TX and RX requested in the same idle cycle
    clear_rx(); e0 = eop_cnt; d0 = done_cnt;
    @(posedge clk); #1 push_total += 20;
    tx_got.delete();
    send_tx(16);
    wait_done(d0 + 1, 400, "t5");
    check("t5_rx_waits", rx_got.size(), 0);
    wait_eop(e0 + 1, 200, "t5");
    repeat (3) @(negedge clk);
    check("t5_tx_count", tx_got.size(), 16);
    for (int i = 0; i < tx_got.size() && i < 16; i++) check("t5_tx_word", tx_got[i], mem[i]);
    check("t5_turn_gap", last_gap >= TURN_CYC, 1);
    check_rx("t5");

    // 300-word backlog splits into 256 + 44
    clear_rx(); e0 = eop_cnt; rdy_mode = 1;
    push_total += 300;
    wait_eop(e0 + 2, 3000, "t5b");
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    check("t5b_bursts", burst_lens.size(), 2);
    check("t5b_burst0", (burst_lens.size() > 0) ? burst_lens[0] : -1, 256);
    check("t5b_burst1", (burst_lens.size() > 1) ? burst_lens[1] : -1, 44);
    check_rx("t5b");

    // Reset in the middle of a 200-word TX
    full_mode = 0; tx_got.delete(); d0 = done_cnt; p0 = pkend_cnt;
    send_tx(200);
    n = 0;
    while (tx_got.size() < 100 && n < 1000) begin @(negedge clk); n++; end
    check("t6_reached_100", tx_got.size() >= 100, 1);
    rst = 1'b1;
    #1;
    check("t6_abort", {o_slwr, o_wen, o_tx_busy, o_pkend}, 0);
    repeat (3) @(negedge clk);
    check("t6_no_pkend", pkend_cnt - p0, 0);
    check("t6_no_done", done_cnt - d0, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    run_tx("t6_after_rst", 7, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
